// File: rtl/btn_debounce.sv
// btn_debounce: per-channel button debouncer.
// The raw inputs are synchronized, sampled on each rising edge of the divided
// slow_clk level, and filtered by a four-state FSM per channel that emits
// one-clk press/release pulses.
// Optional auto-repeat while a button is held: define BTN_DEBOUNCE_AUTOREPEAT_EN.
module btn_debounce #(
  parameter int unsigned N_BTN         = 4,
  parameter int unsigned STABLE_CNT    = 3,
  parameter int unsigned REPEAT_START  = 20,
  parameter int unsigned REPEAT_PERIOD = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slow_clk,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic             any_press
);

  localparam int unsigned CNT_W = $clog2(STABLE_CNT + 1);

  localparam logic [1:0] S_IDLE        = 2'd0;
  localparam logic [1:0] S_PRESS_CHK   = 2'd1;
  localparam logic [1:0] S_HELD        = 2'd2;
  localparam logic [1:0] S_RELEASE_CHK = 2'd3;

  logic             r_slow_d;
  logic             w_strobe;
  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;
  logic [N_BTN-1:0] w_press_nxt;
  logic [N_BTN-1:0] w_release_nxt;
  logic [N_BTN-1:0] w_level_nxt;

  // Sample-rate edge detect and two-flop input synchronizer.
  // slow_d resets high so a slow_clk already high at reset release is not a strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slow_d <= 1'b1;
      r_sync1  <= '0;
      r_sync2  <= '0;
    end else begin
      r_slow_d <= slow_clk;
      r_sync1  <= btn_raw;
      r_sync2  <= r_sync1;
    end
  end

  assign w_strobe = slow_clk & ~r_slow_d;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_hit;
    logic             w_press_c;
    logic             w_release_c;

    // Saturating increment; w_hit marks the sample that completes a stable run.
    assign w_cnt_inc = (r_cnt >= CNT_W'(STABLE_CNT)) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_hit     = (w_cnt_inc == CNT_W'(STABLE_CNT));

    // Channel state and stability counter register.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end

    // Next-state logic; only strobe cycles move the FSM. IDLE and HELD keep
    // cnt at zero, so the same increment path also covers STABLE_CNT == 1.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_press_c   = 1'b0;
      w_release_c = 1'b0;
      if (w_strobe) begin
        case (r_state)
          S_IDLE, S_PRESS_CHK: begin
            if (r_sync2[g]) begin
              if (w_hit) begin
                w_state_nxt = S_HELD;
                w_cnt_nxt   = '0;
                w_press_c   = 1'b1;
              end else begin
                w_state_nxt = S_PRESS_CHK;
                w_cnt_nxt   = w_cnt_inc;
              end
            end else begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = '0;
            end
          end
          S_HELD, S_RELEASE_CHK: begin
            if (!r_sync2[g]) begin
              if (w_hit) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_release_c = 1'b1;
              end else begin
                w_state_nxt = S_RELEASE_CHK;
                w_cnt_nxt   = w_cnt_inc;
              end
            end else begin
              w_state_nxt = S_HELD;
              w_cnt_nxt   = '0;
            end
          end
        endcase
      end
    end

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_START > REPEAT_PERIOD) ? REPEAT_START
                                                                     : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] r_rpt;
    logic [RPT_W-1:0] w_rpt_nxt;
    logic [RPT_W-1:0] w_rpt_inc;
    logic [RPT_W-1:0] w_rpt_tgt;
    logic             r_rpt_first;
    logic             w_rpt_first_nxt;
    logic             w_rpt_c;

    // The counter restarts after every repeat pulse, so it never exceeds RPT_MAX.
    assign w_rpt_inc = r_rpt + RPT_W'(1);
    assign w_rpt_tgt = r_rpt_first ? RPT_W'(REPEAT_START) : RPT_W'(REPEAT_PERIOD);

    // Repeat counter register.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_rpt       <= '0;
        r_rpt_first <= 1'b1;
      end else begin
        r_rpt       <= w_rpt_nxt;
        r_rpt_first <= w_rpt_first_nxt;
      end
    end

    // Count held strobes: first repeat after REPEAT_START, then every REPEAT_PERIOD.
    always_comb begin
      w_rpt_nxt       = r_rpt;
      w_rpt_first_nxt = r_rpt_first;
      w_rpt_c         = 1'b0;
      if (r_state != S_HELD) begin
        w_rpt_nxt       = '0;
        w_rpt_first_nxt = 1'b1;
      end else if (w_strobe) begin
        if (r_sync2[g]) begin
          if (w_rpt_inc >= w_rpt_tgt) begin
            w_rpt_nxt       = '0;
            w_rpt_first_nxt = 1'b0;
            w_rpt_c         = 1'b1;
          end else begin
            w_rpt_nxt = w_rpt_inc;
          end
        end else begin
          w_rpt_nxt       = '0;
          w_rpt_first_nxt = 1'b1;
        end
      end
    end

    assign w_press_nxt[g] = w_press_c | w_rpt_c;
`else
    assign w_press_nxt[g] = w_press_c;
`endif
    assign w_release_nxt[g] = w_release_c;
    assign w_level_nxt[g]   = (w_state_nxt == S_HELD) || (w_state_nxt == S_RELEASE_CHK);
  end

`ifndef BTN_DEBOUNCE_AUTOREPEAT_EN
  // Repeat parameters have no function in this build.
  logic w_unused_rpt;
  assign w_unused_rpt = ^{32'(REPEAT_START), 32'(REPEAT_PERIOD)};
`endif

  // Registered outputs: level and pulses change together, one clk after the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_level     <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      any_press     <= 1'b0;
    end else begin
      btn_level     <= w_level_nxt;
      press_pulse   <= w_press_nxt;
      release_pulse <= w_release_nxt;
      any_press     <= |w_press_nxt;
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: table-driven bench for btn_debounce (STABLE_CNT=3,
// slow_clk period 10 clk). Expected pulses are queued when a strobe is driven
// and popped by a negedge monitor when the DUT emits them.
module tb_btn_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic       slow_clk;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;
  logic       any_press;

  always #5 clk = ~clk;

  btn_debounce #(
    .N_BTN        (4),
    .STABLE_CNT   (3),
    .REPEAT_START (4),
    .REPEAT_PERIOD(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .slow_clk     (slow_clk),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .any_press    (any_press)
  );

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  typedef struct {
    logic [3:0] raw;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] lvl;
  } vec_t;

  typedef struct {
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] lvl;
    int         strobe;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_assert  = 0;
  int   n_fail    = 0;
  int   strobe_no = 0;
  int   hi_cnt    = 0;
  bit   mon_en    = 1'b0;

  // Monitor: any_press every cycle; every pulse must match the queue head,
  // arrive one clk after its strobe edge, and carry the expected level.
  always @(negedge clk) begin
    exp_t e;
    if (slow_clk) hi_cnt++;
    else hi_cnt = 0;
    if (mon_en) begin
      n_assert++;
      if (any_press !== (|press_pulse)) begin
        n_fail++;
        $display("FAIL any_press: got %b want %b (press=%b)", any_press, |press_pulse, press_pulse);
      end
      if ((press_pulse | release_pulse) != 4'b0) begin
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse: got press=%b release=%b after strobe %0d, want none",
                   press_pulse, release_pulse, strobe_no);
        end else begin
          e = exp_q.pop_front();
          if (press_pulse !== e.prs || release_pulse !== e.rel || btn_level !== e.lvl ||
              strobe_no != e.strobe || hi_cnt != 2) begin
            n_fail++;
            $display("FAIL pulse: got press=%b rel=%b lvl=%b strobe=%0d phase=%0d want press=%b rel=%b lvl=%b strobe=%0d phase=2",
                     press_pulse, release_pulse, btn_level, strobe_no, hi_cnt,
                     e.prs, e.rel, e.lvl, e.strobe);
          end
        end
      end
    end
  end

  // One slow_clk period with btn_raw held at raw; queue the pulse it should cause.
  task automatic run_step(input logic [3:0] raw, input logic [3:0] prs,
                          input logic [3:0] rel, input logic [3:0] lvl);
    @(posedge clk); #1;
    slow_clk = 1'b0;
    btn_raw  = raw;
    repeat (5) @(posedge clk);
    #1;
    slow_clk = 1'b1;
    strobe_no++;
    if ((prs | rel) != 4'b0) exp_q.push_back('{prs, rel, lvl, strobe_no});
    repeat (4) @(posedge clk);
    #2;
    n_assert++;
    if (btn_level !== lvl) begin
      n_fail++;
      $display("FAIL level: got %b want %b after strobe %0d", btn_level, lvl, strobe_no);
    end
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missed_pulse: got none want press=%b rel=%b after strobe %0d",
               exp_q[0].prs, exp_q[0].rel, strobe_no);
      exp_q.delete();
    end
  endtask

  task automatic chk_zero(input string tag);
    n_assert++;
    if ({btn_level, press_pulse, release_pulse, any_press} !== 13'b0) begin
      n_fail++;
      $display("FAIL %s: got lvl=%b press=%b rel=%b any=%b want all 0",
               tag, btn_level, press_pulse, release_pulse, any_press);
    end
  endtask

  task automatic add(input logic [3:0] raw, input logic [3:0] prs,
                     input logic [3:0] rel, input logic [3:0] lvl);
    tbl.push_back('{raw, prs, rel, lvl});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    slow_clk = 1'b0;
    btn_raw  = 4'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_state");
    rst = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    chk_zero("post_reset");

    // clean press on ch0
    add(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0001, 4'b0000, 4'b0001);
    add(4'b0001, 4'b0000, 4'b0000, 4'b0001);
    add(4'b0001, 4'b0000, 4'b0000, 4'b0001);
    // bounce on ch1: 2 high, 1 low, 3 high
    add(4'b0011, 4'b0000, 4'b0000, 4'b0001);
    add(4'b0011, 4'b0000, 4'b0000, 4'b0001);
    add(4'b0001, 4'b0000, 4'b0000, 4'b0001);
    add(4'b0011, 4'b0000, 4'b0000, 4'b0001);
    add(4'b0011, 4'b0000, 4'b0000, 4'b0001);
    add(4'b0011, 4'b0010, 4'b0000, 4'b0011);
    // release ch0
    add(4'b0010, 4'b0000, 4'b0000, 4'b0011);
    add(4'b0010, 4'b0000, 4'b0000, 4'b0011);
    add(4'b0010, 4'b0000, 4'b0001, 4'b0010);
    // release bounce on ch1
    add(4'b0000, 4'b0000, 4'b0000, 4'b0010);
    add(4'b0010, 4'b0000, 4'b0000, 4'b0010);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0010);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0010);
    add(4'b0000, 4'b0000, 4'b0010, 4'b0000);
    // simultaneous press/release on ch3:2
    add(4'b1100, 4'b0000, 4'b0000, 4'b0000);
    add(4'b1100, 4'b0000, 4'b0000, 4'b0000);
    add(4'b1100, 4'b1100, 4'b0000, 4'b1100);
    add(4'b0000, 4'b0000, 4'b0000, 4'b1100);
    add(4'b0000, 4'b0000, 4'b0000, 4'b1100);
    add(4'b0000, 4'b0000, 4'b1100, 4'b0000);
    // presses and releases landing in the same cycle
    add(4'b0011, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0011, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0011, 4'b0011, 4'b0000, 4'b0011);
    add(4'b1100, 4'b0000, 4'b0000, 4'b0011);
    add(4'b1100, 4'b0000, 4'b0000, 4'b0011);
    add(4'b1100, 4'b1100, 4'b0011, 4'b1100);
    add(4'b0000, 4'b0000, 4'b0000, 4'b1100);
    add(4'b0000, 4'b0000, 4'b0000, 4'b1100);
    add(4'b0000, 4'b0000, 4'b1100, 4'b0000);

    foreach (tbl[i]) run_step(tbl[i].raw, tbl[i].prs, tbl[i].rel, tbl[i].lvl);

    // long hold on ch0: repeats at held strobes 4,6,8,10 only when enabled
    run_step(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    run_step(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    run_step(4'b0001, 4'b0001, 4'b0000, 4'b0001);
    for (int k = 1; k <= 10; k++) begin
      run_step(4'b0001, (AR && k >= 4 && (k % 2) == 0) ? 4'b0001 : 4'b0000, 4'b0000, 4'b0001);
    end
    run_step(4'b0000, 4'b0000, 4'b0000, 4'b0001);
    run_step(4'b0000, 4'b0000, 4'b0000, 4'b0001);
    run_step(4'b0000, 4'b0000, 4'b0001, 4'b0000);

    // reset while ch0 is in PRESS_CHK with cnt=2 and slow_clk high
    run_step(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    run_step(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_zero("rst_in_press_chk");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst_no_strobe");
    run_step(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    run_step(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    run_step(4'b0001, 4'b0001, 4'b0000, 4'b0001);

    // reset while held: level drops, no release pulse, channel is idle after
    run_step(4'b0001, 4'b0000, 4'b0000, 4'b0001);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_zero("rst_in_held");
    run_step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    run_step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    run_step(4'b0000, 4'b0000, 4'b0000, 4'b0000);

    repeat (3) @(posedge clk);
    #1;
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_pulses: got %0d outstanding want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 The block SHALL have parameter N_BTN, default 4, giving the number of independent button channels (range 1..16).
REQ-002 The block SHALL have parameter STABLE_CNT, default 3, giving the number of consecutive equal samples needed to accept a level change (range 1..15).
REQ-003 The block SHALL have parameter REPEAT_START, default 20, giving the number of sample strobes in HELD before the first auto-repeat pulse.
REQ-004 The block SHALL have parameter REPEAT_PERIOD, default 5, giving the number of sample strobes between later auto-repeat pulses.
REQ-005 The block SHALL have port clk, input, width 1: the single system clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-007 The block SHALL have port slow_clk, input, width 1: divided square wave from the clock divider, used only as a sample-rate level (not a clock).
REQ-008 The block SHALL have port btn_raw, input, width N_BTN: asynchronous, bouncing button inputs, active-high.
REQ-009 The block SHALL have port btn_level, output, width N_BTN: debounced level per button.
REQ-010 The block SHALL have port press_pulse, output, width N_BTN: one-clk pulse per accepted press (and per auto-repeat).
REQ-011 The block SHALL have port release_pulse, output, width N_BTN: one-clk pulse per accepted release.
REQ-012 The block SHALL have port any_press, output, width 1: OR-reduction of press_pulse, driven in the same cycle.

Function
REQ-013 The block SHALL register slow_clk into slow_d and generate strobe = slow_clk & ~slow_d, a one-clk pulse per slow_clk rising edge.
REQ-014 Each btn_raw bit SHALL pass through a 2-flop synchronizer; only the synchronized value (sync) is sampled.
REQ-015 Each channel SHALL run an independent FSM with states IDLE, PRESS_CHK, HELD, RELEASE_CHK and a stability counter wide enough to hold STABLE_CNT.
REQ-016 FSM transitions SHALL occur only on strobe cycles; with no strobe, state and counters hold.
REQ-017 IDLE: on strobe with sync=1, go to PRESS_CHK with cnt=1; if STABLE_CNT==1, go directly to HELD and pulse.
REQ-018 PRESS_CHK: on strobe with sync=1, increment cnt; when cnt reaches STABLE_CNT, go to HELD and assert press_pulse; on strobe with sync=0, return to IDLE with cnt=0.
REQ-019 HELD and RELEASE_CHK SHALL mirror IDLE and PRESS_CHK with sync=0: reaching STABLE_CNT lows enters IDLE and asserts release_pulse; a high sample returns the channel to HELD.
REQ-020 btn_level SHALL be 1 exactly while the channel is in HELD or RELEASE_CHK.
REQ-021 press_pulse and release_pulse SHALL be registered and high for exactly one clk, in the cycle after the deciding strobe; btn_level SHALL change in that same cycle.
REQ-022 Simultaneous events on several channels SHALL be reported in the same cycle without priority or loss.
REQ-023 Counters SHALL saturate and never wrap; a strobe arriving during a pulse cycle SHALL be processed normally.

Reset
REQ-024 During rst=1: all FSMs go to IDLE, all counters clear, synchronizers clear, and all outputs are 0 in the following cycle.
REQ-025 During rst=1, slow_d SHALL reset to 1, so no strobe occurs after reset until slow_clk makes a genuine low-to-high transition.
REQ-026 Reset asserted mid-operation (any state) SHALL abort the operation without emitting any pulse.

Configuration
REQ-027 With macro BTN_DEBOUNCE_AUTOREPEAT_EN defined, a per-channel repeat counter SHALL count strobes while in HELD, clear on any other state, and assert an extra press_pulse after REPEAT_START strobes and then every REPEAT_PERIOD strobes.
REQ-028 Without BTN_DEBOUNCE_AUTOREPEAT_EN, no repeat logic SHALL exist, press_pulse SHALL fire once per accepted press, and REPEAT_START and REPEAT_PERIOD SHALL be ignored.

Verification (STABLE_CNT=3, slow_clk period 10 clk)
REQ-029 Clean press: btn_raw[0]=1 for 5 strobes -> press_pulse[0]=1 for one clk after the 3rd high strobe; btn_level[0]=1 from that cycle; any_press=1 for the same clk.
REQ-030 Bounce: btn_raw[1] high for 2 strobes, low for 1, high for 3 -> exactly one press_pulse[1], after the final 3rd consecutive high.
REQ-031 Release: btn_raw[0] falls and stays low for 3 strobes -> release_pulse[0] for one clk; btn_level[0]=0 in the same cycle.
REQ-032 Simultaneous: btn_raw[3:2] rise together -> press_pulse[3:2]=2'b11 in the same clk; any_press high for one clk.
REQ-033 Reset: rst pulsed while channel 0 is in PRESS_CHK with cnt=2 and slow_clk high -> all outputs 0, no pulse, no strobe until the next slow_clk rising edge.
REQ-034 Autorepeat (macro defined, REPEAT_START=4, REPEAT_PERIOD=2): hold 10 strobes past HELD entry -> extra pulses at strobes 4, 6, 8, 10; with the macro undefined -> none.
